// File: rtl/pipelined_shifter.sv
// Pipelined barrel shifter/rotator with sign-extend and pass modes, valid/ready
// handshakes on both sides, a sideband tag and a synchronous flush.
module pipelined_shifter #(
    parameter int WIDTH       = 32,
    parameter int PIPE_STAGES = 2,
    parameter int TAG_WIDTH   = 4
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      FLUSH,
    input  logic                      IN_VALID,
    output logic                      IN_READY,
    input  logic [WIDTH-1:0]          IN,
    input  logic [$clog2(WIDTH)-1:0]  SHFT,
    input  logic [2:0]                MODE,
    input  logic [TAG_WIDTH-1:0]      IN_TAG,
    output logic                      OUT_VALID,
    input  logic                      OUT_READY,
    output logic [WIDTH-1:0]          OUT,
    output logic [TAG_WIDTH-1:0]      OUT_TAG
);

    localparam int SW = $clog2(WIDTH);
    // Power-of-two shift steps handled by each stage, rounded up so early stages take the extra.
    localparam int STEPS_PER_STAGE = (SW + PIPE_STAGES - 1) / PIPE_STAGES;

    typedef enum logic [2:0] {
        MODE_SLL    = 3'd0,
        MODE_SRL    = 3'd1,
        MODE_SRA    = 3'd2,
        MODE_ROL    = 3'd3,
        MODE_ROR    = 3'd4,
        MODE_SEXT8  = 3'd5,
        MODE_SEXT16 = 3'd6,
        MODE_PASS   = 3'd7
    } mode_e;

    logic [WIDTH-1:0]     data_q [PIPE_STAGES];
    logic [TAG_WIDTH-1:0] tag_q  [PIPE_STAGES];
    logic [2:0]           mode_q [PIPE_STAGES];
    logic [SW-1:0]        shft_q [PIPE_STAGES];
    logic [PIPE_STAGES-1:0] valid_q;

    logic [WIDTH-1:0]     src_data [PIPE_STAGES];
    logic [TAG_WIDTH-1:0] src_tag  [PIPE_STAGES];
    logic [2:0]           src_mode [PIPE_STAGES];
    logic [SW-1:0]        src_shft [PIPE_STAGES];
    logic [PIPE_STAGES-1:0] src_valid;
    logic [WIDTH-1:0]     nxt_data [PIPE_STAGES];

    logic [PIPE_STAGES-1:0] en;
    logic                   in_fire;
    logic [WIDTH-1:0]       pre_data;

    // Applies only the shift steps whose bit index lies in [lo, hi).
    function automatic logic [WIDTH-1:0] shift_steps(
        input logic [WIDTH-1:0] d,
        input logic [2:0]       m,
        input logic [SW-1:0]    sh,
        input int               lo,
        input int               hi
    );
        logic [WIDTH-1:0] r;
        r = d;
        for (int b = 0; b < SW; b++) begin
            if (b >= lo && b < hi && sh[b]) begin
                case (mode_e'(m))
                    MODE_SLL: r = r << (2 ** b);
                    MODE_SRL: r = r >> (2 ** b);
                    MODE_SRA: r = $unsigned($signed(r) >>> (2 ** b));
                    MODE_ROL: r = (r << (2 ** b)) | (r >> (WIDTH - 2 ** b));
                    MODE_ROR: r = (r >> (2 ** b)) | (r << (WIDTH - 2 ** b));
                    default:  r = r;
                endcase
            end
        end
        return r;
    endfunction

    // A stage may load when it is empty or its item moves on this cycle.
    always_comb begin : ready_chain
        logic nxt_ready;
        nxt_ready = OUT_READY;
        en = '0;
        for (int s = PIPE_STAGES - 1; s >= 0; s--) begin
            nxt_ready = !valid_q[s] || nxt_ready;
            en[s] = nxt_ready;
        end
    end

    assign IN_READY = !RST && !FLUSH && en[0];
    assign in_fire  = IN_VALID && IN_READY;

    always_comb begin
        pre_data = IN;
        case (mode_e'(MODE))
            MODE_SEXT8:  pre_data = {{(WIDTH-8){IN[7]}}, IN[7:0]};
            MODE_SEXT16: pre_data = {{(WIDTH-16){IN[15]}}, IN[15:0]};
            default:     pre_data = IN;
        endcase
    end

    always_comb begin
        src_data[0]  = pre_data;
        src_tag[0]   = IN_TAG;
        src_mode[0]  = MODE;
        src_shft[0]  = SHFT;
        src_valid[0] = in_fire;
        for (int s = 1; s < PIPE_STAGES; s++) begin
            src_data[s]  = data_q[s-1];
            src_tag[s]   = tag_q[s-1];
            src_mode[s]  = mode_q[s-1];
            src_shft[s]  = shft_q[s-1];
            src_valid[s] = valid_q[s-1];
        end
        for (int s = 0; s < PIPE_STAGES; s++) begin
            nxt_data[s] = shift_steps(src_data[s], src_mode[s], src_shft[s],
                                      s * STEPS_PER_STAGE, (s + 1) * STEPS_PER_STAGE);
        end
    end

    // Flush only drops valid bits; payload registers keep their old contents.
    always_ff @(posedge CLK) begin
        if (RST) begin
            valid_q <= '0;
            for (int s = 0; s < PIPE_STAGES; s++) begin
                data_q[s] <= '0;
                tag_q[s]  <= '0;
                mode_q[s] <= '0;
                shft_q[s] <= '0;
            end
        end else begin
            for (int s = 0; s < PIPE_STAGES; s++) begin
                if (FLUSH) begin
                    valid_q[s] <= 1'b0;
                end else if (en[s]) begin
                    valid_q[s] <= src_valid[s];
                    if (src_valid[s]) begin
                        data_q[s] <= nxt_data[s];
                        tag_q[s]  <= src_tag[s];
                        mode_q[s] <= src_mode[s];
                        shft_q[s] <= src_shft[s];
                    end
                end
            end
        end
    end

    assign OUT_VALID = valid_q[PIPE_STAGES-1];
    assign OUT       = data_q[PIPE_STAGES-1];
    assign OUT_TAG   = tag_q[PIPE_STAGES-1];

endmodule

// File: tb/tb_pipelined_shifter.sv
// Bench for pipelined_shifter (WIDTH=32, PIPE_STAGES=2): vector table plus stall,
// flush, reset and random-backpressure sequences checked through a scoreboard.
module tb_pipelined_shifter;

    logic        CLK = 1'b0;
    logic        RST;
    logic        FLUSH;
    logic        IN_VALID;
    logic        IN_READY;
    logic [31:0] IN;
    logic [4:0]  SHFT;
    logic [2:0]  MODE;
    logic [3:0]  IN_TAG;
    logic        OUT_VALID;
    logic        OUT_READY;
    logic [31:0] OUT;
    logic [3:0]  OUT_TAG;

    pipelined_shifter #(.WIDTH(32), .PIPE_STAGES(2), .TAG_WIDTH(4)) dut (
        .CLK(CLK), .RST(RST), .FLUSH(FLUSH),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN(IN), .SHFT(SHFT),
        .MODE(MODE), .IN_TAG(IN_TAG),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT(OUT), .OUT_TAG(OUT_TAG)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [2:0]  mode;
        logic [31:0] din;
        logic [4:0]  sh;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  tag;
        int          acc;
    } sb_t;

    vec_t        vecs [16];
    sb_t         sb [$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          delivered = 0;
    logic [31:0] cur_exp = '0;
    bit          check_lat = 0;
    bit          rand_ready = 0;
    bit          hold = 0;
    logic [31:0] hold_out;
    logic [3:0]  hold_tag;

    always @(posedge CLK) cyc++;

    function automatic logic [31:0] model(input logic [2:0] m, input logic [31:0] d, input logic [4:0] s);
        logic [63:0] t;
        case (m)
            3'd0: return d << s;
            3'd1: return d >> s;
            3'd2: return $unsigned($signed(d) >>> s);
            3'd3: begin t = {d, d} << s; return t[63:32]; end
            3'd4: begin t = {d, d} >> s; return t[31:0]; end
            3'd5: return {{24{d[7]}}, d[7:0]};
            3'd6: return {{16{d[15]}}, d[15:0]};
            default: return d;
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard: pop on output handshake, push on input handshake, watch stalled outputs.
    always @(negedge CLK) begin
        if (RST || FLUSH) begin
            sb.delete();
            hold = 0;
        end else begin
            if (hold) begin
                checkOutput("hold_valid", OUT_VALID, 1);
                checkOutput("hold_data", OUT, hold_out);
                checkOutput("hold_tag", OUT_TAG, hold_tag);
            end
            if (OUT_VALID && OUT_READY) begin
                delivered++;
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpected_out: got tag %0h data %0h, expected nothing", OUT_TAG, OUT);
                end else begin
                    sb_t e;
                    e = sb.pop_front();
                    checkOutput("out_data", OUT, e.data);
                    checkOutput("out_tag", OUT_TAG, e.tag);
                    if (check_lat) checkOutput("latency", cyc - e.acc, 2);
                end
            end
            if (IN_VALID && IN_READY) sb.push_back('{cur_exp, IN_TAG, cyc});
            hold = OUT_VALID && !OUT_READY;
            hold_out = OUT;
            hold_tag = OUT_TAG;
        end
    end

    initial begin
        forever begin
            @(posedge CLK);
            #1;
            if (rand_ready) OUT_READY = 1'($urandom_range(0, 1));
        end
    end

    // Called just after a rising edge; returns after the handshake edge.
    task automatic applyStimulus(input logic [2:0] m, input logic [31:0] d, input logic [4:0] s,
                                 input logic [3:0] t, input logic [31:0] e, output int waited);
        waited = 0;
        MODE = m; IN = d; SHFT = s; IN_TAG = t; cur_exp = e;
        IN_VALID = 1;
        forever begin
            @(negedge CLK);
            if (IN_READY) break;
            waited++;
            if (waited > 60) begin
                total++;
                bad++;
                $display("[TB] FAIL accept_timeout: IN_READY stuck at 0, expected 1");
                break;
            end
        end
        @(posedge CLK);
        #1;
        IN_VALID = 0;
    endtask

    task automatic setItem(input int k);
        MODE = 3'(k % 8);
        IN = 32'h13579BDF ^ (32'(k) * 32'h01010101);
        SHFT = 5'(k * 7);
        IN_TAG = 4'(9 + k);
        cur_exp = model(MODE, IN, SHFT);
    endtask

    task automatic waitDrain();
        int n = 0;
        while ((sb.size() != 0 || OUT_VALID) && n < 100) begin
            @(negedge CLK);
            n++;
        end
        checkOutput("drain_empty", sb.size(), 0);
        @(posedge CLK);
        #1;
    endtask

    initial begin
        int w, acc, k, d0;
        vecs[0]  = '{3'd3, 32'h80000001, 5'd1,  32'h00000003};
        vecs[1]  = '{3'd4, 32'h80000001, 5'd1,  32'hC0000000};
        vecs[2]  = '{3'd2, 32'h80000000, 5'd31, 32'hFFFFFFFF};
        vecs[3]  = '{3'd1, 32'h80000000, 5'd31, 32'h00000001};
        vecs[4]  = '{3'd0, 32'h00000001, 5'd31, 32'h80000000};
        vecs[5]  = '{3'd5, 32'h12345680, 5'd7,  32'hFFFFFF80};
        vecs[6]  = '{3'd6, 32'h00007FFF, 5'd3,  32'h00007FFF};
        vecs[7]  = '{3'd7, 32'hDEADBEEF, 5'd5,  32'hDEADBEEF};
        vecs[8]  = '{3'd3, 32'h12345678, 5'd0,  32'h12345678};
        vecs[9]  = '{3'd4, 32'h12345678, 5'd8,  32'h78123456};
        vecs[10] = '{3'd0, 32'h0000FFFF, 5'd4,  32'h000FFFF0};
        vecs[11] = '{3'd2, 32'h7FFF0000, 5'd16, 32'h00007FFF};
        vecs[12] = '{3'd5, 32'h0000007F, 5'd9,  32'h0000007F};
        vecs[13] = '{3'd6, 32'h00018000, 5'd2,  32'hFFFF8000};
        vecs[14] = '{3'd3, 32'hF0000000, 5'd4,  32'h0000000F};
        vecs[15] = '{3'd1, 32'hF0000000, 5'd28, 32'h0000000F};

        RST = 1; FLUSH = 0; IN_VALID = 0; IN = '0; SHFT = '0; MODE = '0; IN_TAG = '0;
        OUT_READY = 1;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        checkOutput("rst_out_valid", OUT_VALID, 0);
        checkOutput("rst_out", OUT, 0);
        checkOutput("rst_out_tag", OUT_TAG, 0);
        checkOutput("rst_in_ready", IN_READY, 0);
        @(posedge CLK);
        #1;
        RST = 0;
        @(negedge CLK);
        checkOutput("idle_in_ready", IN_READY, 1);
        @(posedge CLK);
        #1;

        // Back-to-back vectors with OUT_READY high: latency 2, no bubbles, in-order tags.
        check_lat = 1;
        for (int i = 0; i < 16; i++) begin
            applyStimulus(vecs[i].mode, vecs[i].din, vecs[i].sh, 4'(i + 1), vecs[i].exp, w);
            checkOutput("no_bubble", w, 0);
        end
        waitDrain();
        check_lat = 0;

        // Backpressure: only two entries fit, output holds, then resumes without loss.
        d0 = delivered;
        OUT_READY = 0;
        acc = 0;
        k = 0;
        setItem(k);
        IN_VALID = 1;
        repeat (6) begin
            @(negedge CLK);
            if (IN_READY) begin
                acc++;
                @(posedge CLK);
                #1;
                k++;
                setItem(k);
            end else begin
                @(posedge CLK);
                #1;
            end
        end
        checkOutput("stall_accepted", acc, 2);
        @(negedge CLK);
        checkOutput("stall_in_ready", IN_READY, 0);
        checkOutput("stall_out_valid", OUT_VALID, 1);
        @(posedge CLK);
        #1;
        OUT_READY = 1;
        @(negedge CLK);
        checkOutput("refill_same_cycle", IN_READY, 1);
        @(posedge CLK);
        #1;
        IN_VALID = 0;
        waitDrain();
        checkOutput("stall_delivered", delivered - d0, 3);

        // Flush with two operations in flight.
        OUT_READY = 0;
        applyStimulus(3'd0, 32'h0000000F, 5'd2, 4'hD, 32'h0000003C, w);
        applyStimulus(3'd1, 32'h0000F000, 5'd4, 4'hE, 32'h00000F00, w);
        FLUSH = 1;
        MODE = 3'd7; IN = 32'hAAAA5555; SHFT = 5'd0; IN_TAG = 4'hF; cur_exp = 32'hAAAA5555;
        IN_VALID = 1;
        @(negedge CLK);
        checkOutput("flush_in_ready", IN_READY, 0);
        @(posedge CLK);
        #1;
        FLUSH = 0;
        IN_VALID = 0;
        @(negedge CLK);
        checkOutput("flush_out_valid", OUT_VALID, 0);
        d0 = delivered;
        @(posedge CLK);
        #1;
        OUT_READY = 1;
        repeat (5) @(negedge CLK);
        checkOutput("flush_no_output", delivered - d0, 0);
        @(posedge CLK);
        #1;
        applyStimulus(3'd4, 32'h000000FF, 5'd4, 4'h3, 32'hF000000F, w);
        waitDrain();

        // Reset with two operations in flight.
        OUT_READY = 0;
        applyStimulus(3'd2, 32'h80000000, 5'd4, 4'hD, 32'hF8000000, w);
        applyStimulus(3'd6, 32'h00008001, 5'd0, 4'hE, 32'hFFFF8001, w);
        RST = 1;
        IN_VALID = 1;
        @(negedge CLK);
        checkOutput("rst_mid_in_ready", IN_READY, 0);
        @(posedge CLK);
        #1;
        RST = 0;
        IN_VALID = 0;
        @(negedge CLK);
        checkOutput("rst_mid_out_valid", OUT_VALID, 0);
        checkOutput("rst_mid_out", OUT, 0);
        checkOutput("rst_mid_out_tag", OUT_TAG, 0);
        d0 = delivered;
        @(posedge CLK);
        #1;
        OUT_READY = 1;
        repeat (5) @(negedge CLK);
        checkOutput("rst_no_output", delivered - d0, 0);
        @(posedge CLK);
        #1;

        // Random operations under random backpressure.
        d0 = delivered;
        rand_ready = 1;
        for (int i = 0; i < 40; i++) begin
            logic [2:0]  m;
            logic [31:0] d;
            logic [4:0]  s;
            m = 3'($urandom_range(0, 7));
            d = $urandom;
            s = 5'($urandom_range(0, 31));
            applyStimulus(m, d, s, 4'(i), model(m, d, s), w);
        end
        rand_ready = 0;
        OUT_READY = 1;
        waitDrain();
        checkOutput("random_delivered", delivered - d0, 40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipelined_shifter.md
PIPELINED_SHIFTER -- requirements
Module: pipelined_shifter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data width; legal values 16, 32, 64.
REQ-002 SHALL have parameter PIPE_STAGES, default 2, register stages; legal range 1..log2(WIDTH).
REQ-003 SHALL have parameter TAG_WIDTH, default 4, width of the sideband tag carried alongside data.
REQ-004 SHALL have port CLK  input  1  clock; all state updates on the rising edge.
REQ-005 SHALL have port RST  input  1  reset; synchronous and active-high.
REQ-006 SHALL have port FLUSH  input  1  synchronous discard of all in-flight operations.
REQ-007 SHALL have port IN_VALID  input  1  input operation present.
REQ-008 SHALL have port IN_READY  output  1  input operation accepted this cycle when high together with IN_VALID.
REQ-009 SHALL have port IN  input  WIDTH  operand.
REQ-010 SHALL have port SHFT  input  log2(WIDTH)  shift or rotate amount.
REQ-011 SHALL have port MODE  input  3  operation: 0 SLL, 1 SRL, 2 SRA, 3 ROL, 4 ROR, 5 SEXT8, 6 SEXT16, 7 PASS.
REQ-012 SHALL have port IN_TAG  input  TAG_WIDTH  sideband value returned unmodified with the result.
REQ-013 SHALL have port OUT_VALID  output  1  result present.
REQ-014 SHALL have port OUT_READY  input  1  consumer takes the result this cycle when high together with OUT_VALID.
REQ-015 SHALL have port OUT  output  WIDTH  result.
REQ-016 SHALL have port OUT_TAG  output  TAG_WIDTH  tag of the current result.

Function
REQ-017 SHALL implement SLL as IN << SHFT, zero-filled.
REQ-018 SHALL implement SRL as a logical right shift, zero-filled.
REQ-019 SHALL implement SRA as a right shift filled with IN[WIDTH-1].
REQ-020 SHALL implement ROL and ROR as rotation by SHFT modulo WIDTH; SHFT=0 returns IN.
REQ-021 SHALL implement SEXT8 as {IN[7] replicated, IN[7:0]}.
REQ-022 SHALL implement SEXT16 as {IN[15] replicated, IN[15:0]}.
REQ-023 SHALL ignore SHFT for SEXT8, SEXT16 and PASS.
REQ-024 SHALL implement PASS as OUT=IN.
REQ-025 SHALL split the log2(WIDTH) power-of-two shift steps across PIPE_STAGES register stages.
REQ-026 SHALL place the registers so that no stage holds more than ceil(log2(WIDTH)/PIPE_STAGES) steps.
REQ-027 SHALL register MODE, the remaining SHFT bits and the tag with each stage's data.
REQ-028 SHALL have each stage hold a valid bit.
REQ-029 SHALL advance a stage when its successor is empty or advancing itself; the last stage's successor is OUT_READY.
REQ-030 SHALL drive IN_READY = !FLUSH && (first stage empty or advancing); IN_READY may depend combinationally on OUT_READY.
REQ-031 SHALL, with OUT_READY held high, present an operation accepted at edge N on OUT/OUT_TAG with OUT_VALID high after edge N+PIPE_STAGES-1.
REQ-032 SHALL sustain one operation per cycle while OUT_READY is held high.
REQ-033 SHALL preserve operation order and SHALL never drop or duplicate an operation.
REQ-034 SHALL hold OUT, OUT_TAG and OUT_VALID stable while OUT_VALID=1 and OUT_READY=0.
REQ-035 SHALL, at most, fill all PIPE_STAGES entries and then deassert IN_READY while OUT_READY stays low.
REQ-036 SHALL accept a new input in the same cycle the full pipe drains one entry.
REQ-037 SHALL, on FLUSH, clear every valid bit at the edge, accept no input that cycle, and leave OUT_VALID=0 the next cycle.
REQ-038 SHALL have FLUSH leave data registers unchanged.
REQ-039 SHALL make OUT_VALID=0 imply that OUT and OUT_TAG are don't-care.

Reset
REQ-040 SHALL, when RST=1 at an edge, clear all valid bits.
REQ-041 SHALL, after a reset edge, present OUT_VALID=0, OUT=0 and OUT_TAG=0; IN_READY SHALL be 0 while RST=1.
REQ-042 SHALL give RST priority over FLUSH and over any handshake; a reset mid-operation discards all in-flight operations.

Verification (WIDTH=32, PIPE_STAGES=2)
REQ-043 SHALL be verified by: ROL IN=0x80000001, SHFT=1 -> OUT=0x00000003; ROR same operands -> 0xC0000000.
REQ-044 SHALL be verified by: SRA IN=0x80000000, SHFT=31 -> 0xFFFFFFFF; SRL same operands -> 0x00000001; SLL IN=0x1, SHFT=31 -> 0x80000000.
REQ-045 SHALL be verified by: SEXT8 IN=0x12345680, SHFT=7 -> 0xFFFFFF80; SEXT16 IN=0x00007FFF -> 0x00007FFF.
REQ-046 SHALL be verified by: back-to-back tags 1..8 with OUT_READY=1 -> first result 2 cycles after acceptance, then one result per cycle, tags 1..8 in order.
REQ-047 SHALL be verified by: OUT_READY=0 with IN_VALID=1 -> exactly 2 accepted, IN_READY=0, OUT held stable; raising OUT_READY resumes one result per cycle with no loss.
REQ-048 SHALL be verified by: FLUSH (or RST) asserted with 2 operations in flight -> next cycle OUT_VALID=0, and neither flushed tag ever appears.
